// File: rtl/conv_out_burst_align.sv
// Ping-pong burst aligner: sparse adder results fill two banks of BLOCK_WORDS
// words, and each closed bank is replayed as one contiguous ready/valid burst.
module conv_out_burst_align #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 1024,
  parameter int CNT_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  flush,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  blk_last,
  output logic                  overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  localparam logic [CNT_WIDTH:0] BW_L    = (CNT_WIDTH+1)'(BLOCK_WORDS);
  localparam logic [CNT_WIDTH:0] CNT_ONE = (CNT_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [0:2*BLOCK_WORDS-1];
  logic [DATA_WIDTH-1:0] rdata_q, skid_data_q, skid_data_d;

  logic [1:0]                full_q, full_d;
  logic [1:0][CNT_WIDTH:0]   len_q, len_d;
  logic                      wr_bank_q, wr_bank_d;
  logic [CNT_WIDTH:0]        wr_cnt_q, wr_cnt_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [CNT_WIDTH:0]        rd_issue_q, rd_issue_d;
  logic [CNT_WIDTH:0]        rd_cnt_q, rd_cnt_d;
  logic [1:0]                state_q, state_d;
  logic                      rd_vld_q, rd_vld_d;
  logic                      skid_vld_q, skid_vld_d;
  logic                      overflow_q, overflow_d;

  logic               wr_accept, blk_close, rd_issue, pop, burst_done;
  logic               skid_keep, rd_keep;
  logic [CNT_WIDTH:0] pending, rd_len, wr_addr, rd_addr;

  assign ready_in  = !full_q[wr_bank_q];
  assign wr_accept = valid_in & ready_in;
  assign pending   = wr_cnt_q + (CNT_WIDTH+1)'(wr_accept);
  // A write completing the bank and a flush in the same cycle close it once.
  assign blk_close = ready_in & ((wr_accept & (wr_cnt_q == BW_L - CNT_ONE)) |
                                 (flush & (pending != '0)));
  assign wr_addr   = wr_bank_q ? BW_L + wr_cnt_q : wr_cnt_q;

  // Output head is the older of skid register and RAM read register.
  assign rd_len     = len_q[rd_bank_q];
  assign valid_out  = skid_vld_q | rd_vld_q;
  assign pxl_out    = skid_vld_q ? skid_data_q : (rd_vld_q ? rdata_q : '0);
  assign blk_last   = valid_out & (rd_cnt_q == rd_len - CNT_ONE);
  assign pop        = valid_out & ready_out;
  assign burst_done = pop & blk_last;
  assign overflow   = overflow_q;

  // Issue a read only if the two output slots can still hold everything after this edge.
  assign rd_issue = (state_q != S_IDLE) & (rd_issue_q != rd_len) &
                    !(skid_vld_q & rd_vld_q & !pop);
  assign rd_addr  = rd_bank_q ? BW_L + rd_issue_q : rd_issue_q;
  assign skid_keep = skid_vld_q & !pop;
  assign rd_keep   = rd_vld_q & !(pop & !skid_vld_q);

  always_comb begin
    full_d      = full_q;
    len_d       = len_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_issue_d  = rd_issue_q;
    rd_cnt_d    = rd_cnt_q;
    state_d     = state_q;
    overflow_d  = overflow_q | (valid_in & !ready_in);
    skid_data_d = skid_data_q;
    rd_vld_d    = rd_keep | rd_issue;
    skid_vld_d  = skid_keep | (rd_issue & rd_keep);

    if (rd_issue & rd_keep) skid_data_d = rdata_q;

    if (blk_close) begin
      full_d[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]  = pending;
      wr_bank_d         = !wr_bank_q;
      wr_cnt_d          = '0;
    end else if (wr_accept) begin
      wr_cnt_d = wr_cnt_q + CNT_ONE;
    end

    if (rd_issue) rd_issue_d = rd_issue_q + CNT_ONE;
    if (pop)      rd_cnt_d   = rd_cnt_q + CNT_ONE;

    case (state_q)
      S_IDLE:  if (full_q[rd_bank_q]) state_d = S_PRIME;
      S_PRIME: state_d = S_BURST;
      S_BURST: if (burst_done) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_issue_d        = '0;
        rd_cnt_d          = '0;
        state_d           = full_q[!rd_bank_q] ? S_PRIME : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q      <= '0;
      len_q       <= '0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_issue_q  <= '0;
      rd_cnt_q    <= '0;
      state_q     <= S_IDLE;
      rd_vld_q    <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      len_q       <= len_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_issue_q  <= rd_issue_d;
      rd_cnt_q    <= rd_cnt_d;
      state_q     <= state_d;
      rd_vld_q    <= rd_vld_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_addr] <= pxl_in;
    if (rd_issue)  rdata_q <= mem_q[rd_addr];
  end

endmodule
